// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared types for the CPU sequencer.
// States, instruction classes, MID/SID/AMID codes, control-bus field map.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EX1,
    S_EX2,
    S_EX3,
    S_PAUSE,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_NOP,
    C_LDA,
    C_LDB,
    C_ALU,
    C_STA,
    C_JMP,
    C_JZ,
    C_HLT
  } iclass_e;

  typedef enum logic [4:0] {
    U_IR0   = 5'd0,
    U_IR1   = 5'd1,
    U_A     = 5'd2,
    U_B     = 5'd3,
    U_M     = 5'd4,
    U_R0    = 5'd5,
    U_R1    = 5'd6,
    U_AR0   = 5'd7,
    U_AR1   = 5'd8,
    U_PC0   = 5'd9,
    U_PC1   = 5'd10,
    U_SP0   = 5'd11,
    U_SP1   = 5'd12,
    U_PORTA = 5'd13,
    U_PORTB = 5'd14,
    U_PORTC = 5'd15,
    U_PORTD = 5'd16,
    U_SR    = 5'd17,
    U_ALU   = 5'd18
  } unit_e;

  typedef enum logic [1:0] {
    A_PC,
    A_AR,
    A_SP,
    A_R0R1
  } amid_e;

  // Control-bus field placement; bits at and above CB_USED are tied to 0.
  localparam int CB_ALU_LSB   = 0;
  localparam int CB_MID_LSB   = 5;
  localparam int CB_SID_LSB   = 10;
  localparam int CB_AMID_LSB  = 15;
  localparam int CB_MID_EN    = 17;
  localparam int CB_SID_EN    = 18;
  localparam int CB_PC_INR    = 19;
  localparam int CB_HLT       = 20;
  localparam int CB_CLR_TIMER = 21;
  localparam int CB_USED      = 22;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: sequencer <-> datapath bundle.
// master = sequencer (ir0/flags/hlt in; control_bus/step/instr_done/halted out).
interface cpu_sequencer_if #(
  parameter int CB_WIDTH = 33
);
  logic [7:0]          ir0;
  logic [3:0]          flags;
  logic                hlt;
  logic [CB_WIDTH-1:0] control_bus;
  logic [7:0]          step;
  logic                instr_done;
  logic                halted;

  modport master (
    input  ir0, flags, hlt,
    output control_bus, step, instr_done, halted
  );

  modport slave (
    output ir0, flags, hlt,
    input  control_bus, step, instr_done, halted
  );
endinterface

// File: rtl/cpu_seq_decode.sv
// cpu_seq_decode: combinational control word per machine cycle.
// In: state, class, ALU opcode, taken. Out: control_bus, step, instr_done.
module cpu_seq_decode
  import cpu_seq_pkg::*;
#(
  parameter int CB_WIDTH = 33
) (
  input  state_e              state_i,
  input  iclass_e             cls_i,
  input  logic [4:0]          alu_op_i,
  input  logic                taken_i,
  output logic [CB_WIDTH-1:0] control_bus_o,
  output logic [7:0]          step_o,
  output logic                instr_done_o
);

  unit_e mid;
  unit_e sid;
  amid_e amid;
  logic  xfer;
  logic  pc_inr;
  logic  hlt;
  logic  live;

  always_comb begin
    mid          = U_IR0;
    sid          = U_IR0;
    amid         = A_PC;
    xfer         = 1'b0;
    pc_inr       = 1'b0;
    hlt          = 1'b0;
    live         = 1'b1;
    step_o       = 8'h00;
    instr_done_o = 1'b0;
    unique case (state_i)
      S_FETCH: begin
        step_o = 8'h01;
        xfer   = 1'b1;
        mid    = U_M;
        sid    = U_IR0;
        pc_inr = 1'b1;
      end
      S_DECODE: begin
        step_o = 8'h02;
        unique case (cls_i)
          C_NOP: instr_done_o = 1'b1;
          C_LDA: begin
            xfer = 1'b1; mid = U_M; sid = U_A;
            pc_inr = 1'b1; instr_done_o = 1'b1;
          end
          C_LDB: begin
            xfer = 1'b1; mid = U_M; sid = U_B;
            pc_inr = 1'b1; instr_done_o = 1'b1;
          end
          C_ALU: begin
            xfer = 1'b1; mid = U_ALU; sid = U_A;
            instr_done_o = 1'b1;
          end
          C_STA, C_JMP: begin
            xfer = 1'b1; mid = U_M; sid = U_AR0;
            pc_inr = 1'b1;
          end
          C_JZ: begin
            pc_inr = 1'b1;
            if (taken_i) begin
              xfer = 1'b1; mid = U_M; sid = U_AR0;
            end
          end
          C_HLT: begin
            hlt = 1'b1; instr_done_o = 1'b1;
          end
        endcase
      end
      S_EX1: begin
        step_o = 8'h04;
        pc_inr = 1'b1;
        // Untaken JZ just skips the two address bytes.
        if (cls_i == C_JZ && !taken_i) begin
          instr_done_o = 1'b1;
        end else begin
          xfer = 1'b1; mid = U_M; sid = U_AR1;
        end
      end
      S_EX2: begin
        step_o = 8'h08;
        xfer   = 1'b1;
        if (cls_i == C_STA) begin
          amid = A_AR; mid = U_A; sid = U_M;
          instr_done_o = 1'b1;
        end else begin
          mid = U_AR0; sid = U_PC0;
        end
      end
      S_EX3: begin
        step_o = 8'h10;
        xfer   = 1'b1;
        mid    = U_AR1;
        sid    = U_PC1;
        instr_done_o = 1'b1;
      end
      S_PAUSE, S_HALT: begin
        hlt  = 1'b1;
        live = 1'b0;
      end
      S_IDLE: live = 1'b0;
    endcase
  end

  always_comb begin
    control_bus_o = '0;
    control_bus_o[CB_ALU_LSB +: 5]  = live ? alu_op_i : 5'd0;
    control_bus_o[CB_MID_LSB +: 5]  = mid;
    control_bus_o[CB_SID_LSB +: 5]  = sid;
    control_bus_o[CB_AMID_LSB +: 2] = amid;
    control_bus_o[CB_MID_EN]        = xfer;
    control_bus_o[CB_SID_EN]        = xfer;
    control_bus_o[CB_PC_INR]        = pc_inr;
    control_bus_o[CB_HLT]           = hlt;
    control_bus_o[CB_CLR_TIMER]     = instr_done_o;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute FSM driving the CPU control bus.
// Ports: clk, reset (sync, active-low), bus (cpu_sequencer_if.master).
module cpu_sequencer #(
  parameter int CB_WIDTH  = 33,
  parameter int ZFLAG_BIT = 0
) (
  input logic             clk,
  input logic             reset,
  cpu_sequencer_if.master bus
);
  import cpu_seq_pkg::*;

  state_e  state_q;
  state_e  state_d;
  logic    taken_q;
  logic    taken_d;
  logic    taken;
  logic    done;
  iclass_e cls;

  logic unused_flags;
  assign unused_flags = ^bus.flags;

  assign cls = iclass_e'(bus.ir0[7:5]);

  // The zero flag is live in DECODE and frozen for the EX cycles.
  assign taken = (state_q == S_DECODE) ?
                 bus.flags[ZFLAG_BIT] : taken_q;

  cpu_seq_decode #(
    .CB_WIDTH(CB_WIDTH)
  ) u_decode (
    .state_i      (state_q),
    .cls_i        (cls),
    .alu_op_i     (bus.ir0[4:0]),
    .taken_i      (taken),
    .control_bus_o(bus.control_bus),
    .step_o       (bus.step),
    .instr_done_o (done)
  );

  assign bus.instr_done = done;
  assign bus.halted     = (state_q == S_HALT);

  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    if (state_q == S_DECODE) begin
      taken_d = bus.flags[ZFLAG_BIT];
    end
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EX1;
      S_EX1:    state_d = S_EX2;
      S_EX2:    state_d = S_EX3;
      S_EX3:    state_d = S_FETCH;
      S_PAUSE:  state_d = bus.hlt ? S_PAUSE : S_FETCH;
      S_HALT:   state_d = S_HALT;
    endcase
    // hlt is only honoured on instruction boundaries.
    if (done) begin
      if (state_q == S_DECODE && cls == C_HLT) begin
        state_d = S_HALT;
      end else begin
        state_d = bus.hlt ? S_PAUSE : S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench with a per-instruction cycle-table model.
// Drives cpu_sequencer_if.slave side; monitor compares every cycle.
module tb_cpu_sequencer;
  import cpu_seq_pkg::*;

  localparam int CBW = 33;
  localparam int ZB  = 0;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.CB_WIDTH(CBW)) bus ();

  cpu_sequencer #(
    .CB_WIDTH (CBW),
    .ZFLAG_BIT(ZB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [CBW-1:0] cb;
    logic [7:0]     step;
    logic           done;
    logic           halted;
  } exp_t;

  typedef struct {
    int         mid;
    int         sid;
    int         amid;
    bit         x;
    bit         pc;
    bit         h;
    bit         d;
    logic [7:0] st;
  } cyc_t;

  exp_t exp_q[$];
  cyc_t plan_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk(input int mid, input int sid,
                              input int amid, input bit x,
                              input bit pc, input bit h, input bit d,
                              input logic [7:0] st,
                              input logic [4:0] op, input bit live,
                              input bit hd);
    exp_t e;
    e.cb = '0;
    if (live) e.cb[CB_ALU_LSB +: 5] = op;
    if (x) begin
      e.cb[CB_MID_LSB +: 5] = mid[4:0];
      e.cb[CB_SID_LSB +: 5] = sid[4:0];
      e.cb[CB_MID_EN] = 1'b1;
      e.cb[CB_SID_EN] = 1'b1;
    end
    e.cb[CB_AMID_LSB +: 2] = amid[1:0];
    e.cb[CB_PC_INR]    = pc;
    e.cb[CB_HLT]       = h;
    e.cb[CB_CLR_TIMER] = d;
    e.step   = st;
    e.done   = d;
    e.halted = hd;
    return e;
  endfunction

  function automatic exp_t idle_e();
    return mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 5'd0, 0, 0);
  endfunction

  function automatic exp_t pause_e(input bit hd);
    return mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 5'd0, 0, hd);
  endfunction

  task automatic add(input int mid, input int sid, input int amid,
                     input bit x, input bit pc, input bit h,
                     input bit d, input logic [7:0] st);
    cyc_t c;
    c.mid = mid; c.sid = sid; c.amid = amid;
    c.x = x; c.pc = pc; c.h = h; c.d = d; c.st = st;
    plan_q.push_back(c);
  endtask

  // Cycle table per instruction class, FETCH through end.
  task automatic build_plan(input logic [2:0] cls, input bit z);
    plan_q.delete();
    add(4, 0, 0, 1, 1, 0, 0, 8'h01);
    case (cls)
      3'd0: add(0, 0, 0, 0, 0, 0, 1, 8'h02);
      3'd1: add(4, 2, 0, 1, 1, 0, 1, 8'h02);
      3'd2: add(4, 3, 0, 1, 1, 0, 1, 8'h02);
      3'd3: add(18, 2, 0, 1, 0, 0, 1, 8'h02);
      3'd4: begin
        add(4, 7, 0, 1, 1, 0, 0, 8'h02);
        add(4, 8, 0, 1, 1, 0, 0, 8'h04);
        add(2, 4, 1, 1, 0, 0, 1, 8'h08);
      end
      3'd7: add(0, 0, 0, 0, 0, 1, 1, 8'h02);
      default: begin
        if (cls == 3'd5 || z) begin
          add(4, 7, 0, 1, 1, 0, 0, 8'h02);
          add(4, 8, 0, 1, 1, 0, 0, 8'h04);
          add(7, 9, 0, 1, 0, 0, 0, 8'h08);
          add(8, 10, 0, 1, 0, 0, 1, 8'h10);
        end else begin
          add(0, 0, 0, 0, 1, 0, 0, 8'h02);
          add(0, 0, 0, 0, 1, 0, 1, 8'h04);
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pause_len: PAUSE cycles after the end cycle (0 = none).
  // abort_at: plan index whose closing edge samples reset low (-1 = none).
  task automatic run_instr(input logic [7:0] ir, input bit z,
                           input int pause_len, input int abort_at,
                           input bit noise);
    build_plan(ir[7:5], z);
    foreach (plan_q[i]) begin
      cyc_t c;
      c = plan_q[i];
      bus.ir0   = ir;
      bus.flags = 4'($urandom);
      if (i == 1) bus.flags[ZB] = z;
      bus.hlt = noise ? 1'($urandom) : 1'b0;
      if (c.d) bus.hlt = (pause_len > 0);
      if (i == abort_at) reset = 1'b0;
      exp_q.push_back(mk(c.mid, c.sid, c.amid, c.x, c.pc, c.h,
                         c.d, c.st, ir[4:0], 1, 0));
      tick();
      if (i == abort_at) begin
        reset   = 1'b1;
        bus.hlt = noise ? 1'($urandom) : 1'b0;
        exp_q.push_back(idle_e());
        tick();
        return;
      end
    end
    if (ir[7:5] == 3'd7) begin
      for (int k = 0; k < 6; k++) begin
        bus.hlt   = 1'($urandom);
        bus.ir0   = 8'($urandom);
        bus.flags = 4'($urandom);
        exp_q.push_back(pause_e(1));
        tick();
      end
      reset = 1'b0;
      exp_q.push_back(pause_e(1));
      tick();
      reset = 1'b1;
      exp_q.push_back(idle_e());
      tick();
      return;
    end
    for (int p = 0; p < pause_len; p++) begin
      bus.hlt   = (p < pause_len - 1);
      bus.flags = 4'($urandom);
      exp_q.push_back(pause_e(0));
      tick();
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (bus.control_bus !== e.cb || bus.step !== e.step ||
          bus.instr_done !== e.done || bus.halted !== e.halted) begin
        n_err++;
        $display("FAIL vec%0d: got cb=%h step=%h done=%b halted=%b, want cb=%h step=%h done=%b halted=%b",
                 n_vec, bus.control_bus, bus.step, bus.instr_done,
                 bus.halted, e.cb, e.step, e.done, e.halted);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ir;
    int         pl;
    int         ab;
    reset     = 1'b0;
    bus.ir0   = 8'hE3;
    bus.flags = 4'h0;
    bus.hlt   = 1'b0;
    tick();
    repeat (2) begin
      exp_q.push_back(idle_e());
      tick();
    end
    reset = 1'b1;
    exp_q.push_back(idle_e());
    tick();

    run_instr(8'h20, 0, 0, -1, 0);
    run_instr(8'h40, 0, 0, -1, 0);
    run_instr(8'h61, 0, 0, -1, 0);
    run_instr(8'h00, 0, 0, -1, 1);
    run_instr(8'h80, 0, 3, -1, 1);
    run_instr(8'hA0, 0, 0, -1, 0);
    run_instr(8'hC0, 0, 0, -1, 1);
    run_instr(8'hC0, 1, 1, -1, 1);
    run_instr(8'hA0, 0, 0, 3, 0);
    run_instr(8'h80, 0, 0, 2, 1);

    for (int n = 0; n < 200; n++) begin
      ir = 8'($urandom);
      if (ir[7:5] == 3'd7 && $urandom_range(0, 3) != 0) ir[7:5] = 3'd0;
      pl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(ir, 1'($urandom), pl, ab, 1);
    end

    run_instr(8'hE0, 0, 0, -1, 1);
    run_instr(8'h25, 0, 0, -1, 0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
